// File: rtl/multi_port_avalon_arbiter_pkg.sv
// Shared types for the multi-port Avalon arbiter: FSM state encoding and port-index sizing.
// The index width covers the largest supported port count, so every configuration shares one width.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int MAX_PORTS = 8;
    localparam int PIDX_W    = $clog2(MAX_PORTS);

    // Successor of a port index, wrapping at the configured port count.
    function automatic logic [PIDX_W-1:0] wrap_inc(input logic [PIDX_W-1:0] idx, input int nports);
        if (int'(idx) + 1 >= nports) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/multi_port_avalon_arbiter_rr_grant.sv
// Combinational next-grant picker: lowest pending index, or first pending index at/after i_ptr.
// Zero latency; no flow control of its own, o_vld simply reports that some port is pending.
module rr_grant
    import avalon_arb_pkg::*;
#(
    parameter int NPORTS      = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic [NPORTS-1:0] i_pend,
    input  logic [PIDX_W-1:0] i_ptr,
    output logic [PIDX_W-1:0] o_idx,
    output logic              o_vld
);

    always_comb begin
        int j;
        o_idx = '0;
        o_vld = 1'b0;
        j     = 0;
        for (int k = 0; k < NPORTS; k++) begin
            if (ROUND_ROBIN != 0) begin
                j = int'(i_ptr) + k;
                if (j >= NPORTS) begin
                    j = j - NPORTS;
                end
            end else begin
                j = k;
            end
            // Inner scan keeps every bit-select at a constant index.
            for (int p = 0; p < NPORTS; p++) begin
                if (!o_vld && (p == j) && i_pend[p]) begin
                    o_vld = 1'b1;
                    o_idx = PIDX_W'(p);
                end
            end
        end
    end

endmodule

// File: rtl/multi_port_avalon_arbiter.sv
// Merges NPORTS requester ports onto one Avalon-MM master, one transfer at a time, read data banked per port.
// Latency: grant registered one cycle after a request appears; transfers back-to-back, one DONE cycle per batch.
// Backpressure: avl_waitrequest holds the registered avl_* fields; stall holds all requesters until the batch ends.
module multi_port_avalon_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NPORTS      = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       stall,
    input  logic [NPORTS*AW-1:0]       req_address,
    input  logic [NPORTS-1:0]          req_read,
    input  logic [NPORTS-1:0]          req_write,
    input  logic [NPORTS*(DW/8)-1:0]   req_byteenable,
    input  logic [NPORTS*DW-1:0]       req_writedata,
    output logic [NPORTS*DW-1:0]       req_readdata,
    output logic [AW-1:0]              avl_address,
    output logic [(DW/8)-1:0]          avl_byteenable,
    output logic [DW-1:0]              avl_writedata,
    output logic                       avl_read,
    output logic                       avl_write,
    input  logic [DW-1:0]              avl_readdata,
    input  logic                       avl_waitrequest
);

    localparam int BE = DW / 8;

    arb_state_t        r_state;
    logic [NPORTS-1:0] r_served;
    logic [PIDX_W-1:0] r_grant;
    logic [PIDX_W-1:0] r_rr_ptr;
    logic [AW-1:0]     r_avl_address;
    logic [BE-1:0]     r_avl_byteenable;
    logic [DW-1:0]     r_avl_writedata;
    logic              r_avl_read;
    logic              r_avl_write;
    logic [DW-1:0]     r_rdata [NPORTS];

    logic [NPORTS-1:0] w_pending;
    logic [NPORTS-1:0] w_grant_oh;
    logic [NPORTS-1:0] w_pend_sel;
    logic [PIDX_W-1:0] w_grant_inc;
    logic [PIDX_W-1:0] w_ptr_sel;
    logic [PIDX_W-1:0] w_gnt_idx;
    logic              w_gnt_vld;
    logic              w_done_xfer;
    logic              w_capture;
    logic [AW-1:0]     w_sel_address;
    logic [BE-1:0]     w_sel_byteenable;
    logic [DW-1:0]     w_sel_writedata;
    logic              w_sel_read;
    logic              w_sel_write;

    assign w_pending   = (req_read | req_write) & ~r_served;
    assign w_grant_inc = wrap_inc(r_grant, NPORTS);
    assign w_done_xfer = (r_state == BUSY) && !avl_waitrequest;
    assign w_capture   = w_done_xfer && r_avl_read;

    always_comb begin
        w_grant_oh = '0;
        for (int p = 0; p < NPORTS; p++) begin
            w_grant_oh[p] = (r_grant == PIDX_W'(p));
        end
    end

    // While BUSY the picker looks ahead: current grant masked out, pointer already advanced past it.
    assign w_pend_sel = (r_state == BUSY) ? (w_pending & ~w_grant_oh) : w_pending;
    assign w_ptr_sel  = (r_state == BUSY) ? w_grant_inc : r_rr_ptr;

    rr_grant #(
        .NPORTS      (NPORTS),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_rr_grant (
        .i_pend (w_pend_sel),
        .i_ptr  (w_ptr_sel),
        .o_idx  (w_gnt_idx),
        .o_vld  (w_gnt_vld)
    );

    always_comb begin
        w_sel_address    = '0;
        w_sel_byteenable = '0;
        w_sel_writedata  = '0;
        w_sel_read       = 1'b0;
        w_sel_write      = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_gnt_idx == PIDX_W'(p)) begin
                w_sel_address    = req_address[p*AW +: AW];
                w_sel_byteenable = req_byteenable[p*BE +: BE];
                w_sel_writedata  = req_writedata[p*DW +: DW];
                w_sel_write      = req_write[p];
                w_sel_read       = req_read[p] & ~req_write[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_served         <= '0;
            r_grant          <= '0;
            r_rr_ptr         <= '0;
            r_avl_address    <= '0;
            r_avl_byteenable <= '0;
            r_avl_writedata  <= '0;
            r_avl_read       <= 1'b0;
            r_avl_write      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_grant          <= w_gnt_idx;
                        r_avl_address    <= w_sel_address;
                        r_avl_byteenable <= w_sel_byteenable;
                        r_avl_writedata  <= w_sel_writedata;
                        r_avl_read       <= w_sel_read;
                        r_avl_write      <= w_sel_write;
                        r_state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (!avl_waitrequest) begin
                        r_served <= r_served | w_grant_oh;
                        r_rr_ptr <= w_grant_inc;
                        if (w_gnt_vld) begin
                            r_grant          <= w_gnt_idx;
                            r_avl_address    <= w_sel_address;
                            r_avl_byteenable <= w_sel_byteenable;
                            r_avl_writedata  <= w_sel_writedata;
                            r_avl_read       <= w_sel_read;
                            r_avl_write      <= w_sel_write;
                        end else begin
                            r_avl_read  <= 1'b0;
                            r_avl_write <= 1'b0;
                            r_state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_served <= '0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NPORTS; p++) begin
                r_rdata[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (w_capture && w_grant_oh[p]) begin
                    r_rdata[p] <= avl_readdata;
                end
            end
        end
    end

    generate
        for (genvar gp = 0; gp < NPORTS; gp++) begin : g_rdata
            assign req_readdata[gp*DW +: DW] = r_rdata[gp];
        end
    endgenerate

    assign stall          = (r_state == BUSY) || ((r_state == IDLE) && (|w_pending));
    assign avl_address    = r_avl_address;
    assign avl_byteenable = r_avl_byteenable;
    assign avl_writedata  = r_avl_writedata;
    assign avl_read       = r_avl_read;
    assign avl_write      = r_avl_write;

endmodule

// File: tb/tb_multi_port_avalon_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter with a wait-state slave and a 3-port round-robin one.
module tb_multi_port_avalon_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    function automatic int midx(input logic [31:0] a);
        return int'({a[31], a[4:2]});
    endfunction

    // ---------------- fixed-priority instance, NPORTS=2 ----------------
    logic        fp_stall;
    logic [63:0] fp_req_address = '0;
    logic [1:0]  fp_req_read    = '0;
    logic [1:0]  fp_req_write   = '0;
    logic [7:0]  fp_req_be      = '0;
    logic [63:0] fp_req_wdata   = '0;
    logic [63:0] fp_req_rdata;
    logic [31:0] fp_avl_address, fp_avl_wdata, fp_avl_rdata;
    logic [3:0]  fp_avl_be;
    logic        fp_avl_read, fp_avl_write, fp_waitreq;
    logic [31:0] fp_mem [16];
    int          fp_wait_cfg = 0;
    int          fp_wcnt;
    logic [32:0] fp_log [$];
    logic [69:0] fp_prev;
    logic        fp_prev_wait = 1'b0;
    int          fp_viol = 0;

    multi_port_avalon_arbiter #(.NPORTS(2), .AW(32), .DW(32), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst(rst_n), .stall(fp_stall),
        .req_address(fp_req_address), .req_read(fp_req_read), .req_write(fp_req_write),
        .req_byteenable(fp_req_be), .req_writedata(fp_req_wdata), .req_readdata(fp_req_rdata),
        .avl_address(fp_avl_address), .avl_byteenable(fp_avl_be), .avl_writedata(fp_avl_wdata),
        .avl_read(fp_avl_read), .avl_write(fp_avl_write),
        .avl_readdata(fp_avl_rdata), .avl_waitrequest(fp_waitreq)
    );

    assign fp_waitreq   = (fp_avl_read || fp_avl_write) && (fp_wcnt < fp_wait_cfg);
    assign fp_avl_rdata = fp_mem[midx(fp_avl_address)];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_wcnt <= 0;
            for (int i = 0; i < 16; i++) fp_mem[i] <= 32'h0;
            fp_mem[0] <= 32'h0a0b0c0d;
            fp_mem[1] <= 32'h000000ff;
            fp_mem[8] <= 32'h11111111;
        end else if (fp_avl_read || fp_avl_write) begin
            if (fp_waitreq) begin
                fp_wcnt <= fp_wcnt + 1;
            end else begin
                fp_wcnt <= 0;
                fp_log.push_back({fp_avl_write, fp_avl_address});
                if (fp_avl_write)
                    for (int b = 0; b < 4; b++)
                        if (fp_avl_be[b]) fp_mem[midx(fp_avl_address)][b*8 +: 8] <= fp_avl_wdata[b*8 +: 8];
            end
        end
    end

    // Avalon fields must not move while the slave holds waitrequest.
    always @(negedge clk) begin
        if (!rst_n) begin
            fp_prev_wait <= 1'b0;
        end else begin
            if (fp_prev_wait && ({fp_avl_read, fp_avl_write, fp_avl_be, fp_avl_address, fp_avl_wdata} != fp_prev))
                fp_viol <= fp_viol + 1;
            fp_prev      <= {fp_avl_read, fp_avl_write, fp_avl_be, fp_avl_address, fp_avl_wdata};
            fp_prev_wait <= fp_waitreq;
        end
    end

    // ---------------- round-robin instance, NPORTS=3, zero-wait slave ----------------
    logic        rr_stall;
    logic [95:0] rr_req_address = '0;
    logic [2:0]  rr_req_read    = '0;
    logic [2:0]  rr_req_write   = '0;
    logic [11:0] rr_req_be      = '0;
    logic [95:0] rr_req_wdata   = '0;
    logic [95:0] rr_req_rdata;
    logic [31:0] rr_avl_address, rr_avl_wdata, rr_avl_rdata;
    logic [3:0]  rr_avl_be;
    logic        rr_avl_read, rr_avl_write;
    logic        rr_waitreq = 1'b0;
    logic [31:0] rr_mem [16];
    logic [32:0] rr_log [$];

    multi_port_avalon_arbiter #(.NPORTS(3), .AW(32), .DW(32), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst(rst_n), .stall(rr_stall),
        .req_address(rr_req_address), .req_read(rr_req_read), .req_write(rr_req_write),
        .req_byteenable(rr_req_be), .req_writedata(rr_req_wdata), .req_readdata(rr_req_rdata),
        .avl_address(rr_avl_address), .avl_byteenable(rr_avl_be), .avl_writedata(rr_avl_wdata),
        .avl_read(rr_avl_read), .avl_write(rr_avl_write),
        .avl_readdata(rr_avl_rdata), .avl_waitrequest(rr_waitreq)
    );

    assign rr_avl_rdata = rr_mem[midx(rr_avl_address)];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rr_mem[i] <= 32'h0;
            rr_mem[0] <= 32'ha0a0a0a0;
            rr_mem[2] <= 32'h88888888;
            rr_mem[3] <= 32'hcccccccc;
            rr_mem[4] <= 32'hdeadbeef;
        end else if (rr_avl_read || rr_avl_write) begin
            rr_log.push_back({rr_avl_write, rr_avl_address});
            if (rr_avl_write)
                for (int b = 0; b < 4; b++)
                    if (rr_avl_be[b]) rr_mem[midx(rr_avl_address)][b*8 +: 8] <= rr_avl_wdata[b*8 +: 8];
        end
    end

    // ---------------- measurement helpers (no comparisons inside) ----------------
    task automatic count_fp(output int n);
        n = 0;
        while (fp_stall === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_rr(output int n);
        n = 0;
        while (rr_stall === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (fp_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", fp_stall); end
        checks++; if ({fp_avl_read, fp_avl_write} !== 2'b00) begin errors++; $display("FAIL reset_rdwr: got %b want 00", {fp_avl_read, fp_avl_write}); end
        checks++; if ({fp_avl_address, fp_avl_be, fp_avl_wdata} !== 68'h0) begin errors++; $display("FAIL reset_fields: got %h want 0", {fp_avl_address, fp_avl_be, fp_avl_wdata}); end
        checks++; if (fp_req_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", fp_req_rdata); end
        checks++; if (rr_req_rdata !== 96'h0) begin errors++; $display("FAIL reset_rr_rdata: got %h want 0", rr_req_rdata); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({fp_stall, rr_stall} !== 2'b00) begin errors++; $display("FAIL post_reset_stall: got %b want 00", {fp_stall, rr_stall}); end
    endtask

    task automatic test_single_read;
        int n;
        @(negedge clk);
        fp_log.delete();
        fp_req_address[31:0] = 32'hbfc00000;
        fp_req_read = 2'b01;
        #1 count_fp(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL single_stall_cycles: got %0d want 2", n); end
        checks++; if (fp_req_rdata[31:0] !== 32'h11111111) begin errors++; $display("FAIL single_rdata: got %h want 11111111", fp_req_rdata[31:0]); end
        checks++; if (fp_log.size() !== 1) begin errors++; $display("FAIL single_xfers: got %0d want 1", fp_log.size()); end
        fp_req_read = 2'b00;
        @(negedge clk);
        checks++; if (fp_stall !== 1'b0) begin errors++; $display("FAIL single_idle_stall: got %b want 0", fp_stall); end
    endtask

    task automatic test_fixed_priority;
        int n;
        logic [32:0] e0, e1;
        @(negedge clk);
        fp_log.delete();
        fp_req_address = {32'h4, 32'h0};
        fp_req_read    = 2'b01;
        fp_req_write   = 2'b10;
        fp_req_be      = {4'b0001, 4'b1111};
        fp_req_wdata   = {32'hddccbbaa, 32'h0};
        #1 count_fp(n);
        e0 = (fp_log.size() > 0) ? fp_log[0] : '1;
        e1 = (fp_log.size() > 1) ? fp_log[1] : '1;
        checks++; if (n !== 3) begin errors++; $display("FAIL fp_stall_cycles: got %0d want 3", n); end
        checks++; if (fp_log.size() !== 2) begin errors++; $display("FAIL fp_xfers: got %0d want 2", fp_log.size()); end
        checks++; if (e0 !== {1'b0, 32'h0}) begin errors++; $display("FAIL fp_first: got %h want 000000000", e0); end
        checks++; if (e1 !== {1'b1, 32'h4}) begin errors++; $display("FAIL fp_second: got %h want 100000004", e1); end
        checks++; if (fp_req_rdata[31:0] !== 32'h0a0b0c0d) begin errors++; $display("FAIL fp_rdata0: got %h want 0a0b0c0d", fp_req_rdata[31:0]); end
        fp_req_read = 2'b00; fp_req_write = 2'b00;
        @(negedge clk);
        fp_req_read = 2'b10;
        #1 count_fp(n);
        checks++; if (n !== 2) begin errors++; $display("FAIL be_read_cycles: got %0d want 2", n); end
        checks++; if (fp_req_rdata[63:32] !== 32'h000000aa) begin errors++; $display("FAIL be_merge: got %h want 000000aa", fp_req_rdata[63:32]); end
        fp_req_read = 2'b00;
        @(negedge clk);
        // Read and write on one port: only the write goes out, readdata stays put.
        fp_log.delete();
        fp_req_address[31:0] = 32'h8;
        fp_req_wdata[31:0]   = 32'h5a5a5a5a;
        fp_req_be[3:0]       = 4'b1111;
        fp_req_read  = 2'b01;
        fp_req_write = 2'b01;
        #1 count_fp(n);
        e0 = (fp_log.size() > 0) ? fp_log[0] : '1;
        checks++; if (n !== 2) begin errors++; $display("FAIL rw_cycles: got %0d want 2", n); end
        checks++; if (e0 !== {1'b1, 32'h8} || fp_log.size() !== 1) begin errors++; $display("FAIL rw_write_only: got %h x%0d want 100000008 x1", e0, fp_log.size()); end
        checks++; if (fp_req_rdata[31:0] !== 32'h0a0b0c0d) begin errors++; $display("FAIL rw_rdata_kept: got %h want 0a0b0c0d", fp_req_rdata[31:0]); end
        fp_req_read = 2'b00; fp_req_write = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_wait_states;
        int n, hold;
        @(negedge clk);
        fp_wait_cfg = 3;
        fp_req_address[31:0] = 32'hbfc00000;
        fp_req_read = 2'b01;
        #1;
        n = 0; hold = 0;
        while (fp_stall === 1'b1 && n < 50) begin
            n++;
            if (fp_avl_read === 1'b1 && fp_avl_address === 32'hbfc00000) hold++;
            @(negedge clk);
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL wait_stall_cycles: got %0d want 5", n); end
        checks++; if (hold !== 4) begin errors++; $display("FAIL wait_hold_cycles: got %0d want 4", hold); end
        checks++; if (fp_req_rdata[31:0] !== 32'h11111111) begin errors++; $display("FAIL wait_rdata: got %h want 11111111", fp_req_rdata[31:0]); end
        fp_req_read = 2'b00;
        fp_wait_cfg = 0;
        @(negedge clk);
        checks++; if (fp_viol !== 0) begin errors++; $display("FAIL avl_stable_under_wait: got %0d changes want 0", fp_viol); end
    endtask

    task automatic test_reset_mid_busy;
        @(negedge clk);
        fp_wait_cfg = 3;
        fp_req_address[31:0] = 32'h0;
        fp_req_read = 2'b01;
        @(negedge clk);
        checks++; if (fp_avl_read !== 1'b1) begin errors++; $display("FAIL busy_before_reset: got %b want 1", fp_avl_read); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({fp_avl_read, fp_avl_write} !== 2'b00) begin errors++; $display("FAIL async_drop: got %b want 00", {fp_avl_read, fp_avl_write}); end
        checks++; if (fp_req_rdata !== 64'h0) begin errors++; $display("FAIL reset_clears_rdata: got %h want 0", fp_req_rdata); end
        fp_req_read = 2'b00;
        fp_wait_cfg = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (fp_stall !== 1'b0) begin errors++; $display("FAIL reset_idle_stall: got %b want 0", fp_stall); end
        checks++; if (fp_req_rdata !== 64'h0) begin errors++; $display("FAIL no_partial_capture: got %h want 0", fp_req_rdata); end
    endtask

    task automatic test_round_robin;
        int n;
        logic [32:0] e0, e1;
        for (int round = 0; round < 2; round++) begin
            @(negedge clk);
            rr_log.delete();
            rr_req_address = {32'h0, 32'h4, 32'h0};
            rr_req_read    = 3'b001;
            rr_req_write   = 3'b010;
            rr_req_be      = {4'h0, 4'hf, 4'hf};
            rr_req_wdata   = {32'h0, 32'h11223344, 32'h0};
            #1 count_rr(n);
            e0 = (rr_log.size() > 0) ? rr_log[0] : '1;
            e1 = (rr_log.size() > 1) ? rr_log[1] : '1;
            checks++; if (n !== 3) begin errors++; $display("FAIL rr_stall_cycles r%0d: got %0d want 3", round, n); end
            checks++; if (e0 !== ((round == 0) ? {1'b0, 32'h0} : {1'b1, 32'h4})) begin errors++; $display("FAIL rr_first r%0d: got %h", round, e0); end
            checks++; if (e1 !== ((round == 0) ? {1'b1, 32'h4} : {1'b0, 32'h0})) begin errors++; $display("FAIL rr_second r%0d: got %h", round, e1); end
            checks++; if (rr_req_rdata[31:0] !== 32'ha0a0a0a0) begin errors++; $display("FAIL rr_rdata0 r%0d: got %h want a0a0a0a0", round, rr_req_rdata[31:0]); end
            rr_req_read = 3'b000; rr_req_write = 3'b000;
            if (round == 0) begin
                // Lone port 0 read moves the pointer to port 1 for the second round.
                @(negedge clk);
                rr_req_address[31:0] = 32'h8;
                rr_req_read = 3'b001;
                #1 count_rr(n);
                checks++; if (n !== 2) begin errors++; $display("FAIL rr_solo_cycles: got %0d want 2", n); end
                checks++; if (rr_req_rdata[31:0] !== 32'h88888888) begin errors++; $display("FAIL rr_solo_rdata: got %h want 88888888", rr_req_rdata[31:0]); end
                rr_req_read = 3'b000;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_drop_request;
        int n;
        logic [32:0] e0, e1;
        @(negedge clk);
        rr_req_address[95:64] = 32'hc;
        rr_req_read = 3'b100;
        #1 count_rr(n);
        checks++; if (rr_req_rdata[95:64] !== 32'hcccccccc) begin errors++; $display("FAIL drop_setup_rdata2: got %h want cccccccc", rr_req_rdata[95:64]); end
        rr_req_read = 3'b000;
        @(negedge clk);
        rr_log.delete();
        rr_req_address = {32'h10, 32'h4, 32'h0};
        rr_req_read = 3'b111;
        #1;
        n = 0;
        while (rr_stall === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
            if (n == 1) rr_req_read[2] = 1'b0;
        end
        e0 = (rr_log.size() > 0) ? rr_log[0] : '1;
        e1 = (rr_log.size() > 1) ? rr_log[1] : '1;
        checks++; if (n !== 3) begin errors++; $display("FAIL drop_stall_cycles: got %0d want 3", n); end
        checks++; if (rr_log.size() !== 2) begin errors++; $display("FAIL drop_xfers: got %0d want 2", rr_log.size()); end
        checks++; if (e0 !== {1'b0, 32'h0} || e1 !== {1'b0, 32'h4}) begin errors++; $display("FAIL drop_order: got %h %h want 000000000 000000004", e0, e1); end
        checks++; if (rr_req_rdata[95:64] !== 32'hcccccccc) begin errors++; $display("FAIL drop_rdata2_kept: got %h want cccccccc", rr_req_rdata[95:64]); end
        checks++; if (rr_req_rdata[63:0] !== {32'h11223344, 32'ha0a0a0a0}) begin errors++; $display("FAIL drop_rdata01: got %h want 11223344a0a0a0a0", rr_req_rdata[63:0]); end
        rr_req_read = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fixed_priority();
        test_wait_states();
        test_reset_mid_busy();
        test_round_robin();
        test_drop_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
